// File: rtl/rv32i_fetch_unit_if.sv
// Fetch-stage bus bundle: instruction ROM port A, redirect request and the
// instruction/PC stream handed to decode.
interface rv32i_fetch_unit_if #(
    parameter int AWIDTH = 12
);
    logic [AWIDTH-1:0] imem_addr;
    logic [31:0]       imem_rdata;
    logic              redirect_valid;
    logic [31:0]       redirect_pc;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_pc;
    logic [31:0]       out_instr;
    logic              fetch_fault;

    // Fetch unit side
    modport master (
        output imem_addr, out_valid, out_pc, out_instr, fetch_fault,
        input  imem_rdata, redirect_valid, redirect_pc, out_ready
    );

    // ROM / decode / branch-resolution side
    modport slave (
        input  imem_addr, out_valid, out_pc, out_instr, fetch_fault,
        output imem_rdata, redirect_valid, redirect_pc, out_ready
    );
endinterface

// File: rtl/rv32i_fetch_unit.sv
// RV32I instruction fetch stage: owns the PC, drives the synchronous ROM,
// and buffers {pc, instr} pairs in a 2-entry skid FIFO toward decode.
//
// state | meaning
// ------+---------------------------------------------------------------
// RUN   | normal fetch; redirects flush and restart from the target
// HALT  | misaligned redirect seen; no issue/push, left only via rst_n
module rv32i_fetch_unit #(
    parameter int          AWIDTH   = 12,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input logic               clk,
    input logic               rst_n,
    rv32i_fetch_unit_if.master bus
);
    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] fetch_pc_q;
    logic [31:0] tag_q;
    logic        inflight_q;
    logic        fault_q;

    logic [31:0] fifo_pc_q    [2];
    logic [31:0] fifo_instr_q [2];
    logic [1:0]  cnt_q;

    logic        pop;
    logic        push;
    logic        flush;
    logic        issue;
    logic        redir_ok;
    logic        redir_bad;
    logic [31:0] issue_pc;
    logic [2:0]  occupancy;
    logic [1:0]  wr_idx;

    assign bus.out_valid   = (cnt_q != 2'd0);
    assign bus.out_pc      = fifo_pc_q[0];
    assign bus.out_instr   = fifo_instr_q[0];
    assign bus.fetch_fault = fault_q;
    // The redirect target is put on the ROM address in the same cycle so the
    // target instruction comes back one cycle later with no bubble beyond N+1.
    assign bus.imem_addr   = bus.redirect_valid ? bus.redirect_pc[AWIDTH+1:2]
                                                : fetch_pc_q[AWIDTH+1:2];

    // Next state and per-cycle fetch control
    always_comb begin
        state_d   = state_q;
        redir_ok  = 1'b0;
        redir_bad = 1'b0;
        flush     = 1'b0;
        issue     = 1'b0;
        push      = 1'b0;
        issue_pc  = fetch_pc_q;
        pop       = bus.out_valid & bus.out_ready;
        // Entries held plus the one still coming back from the ROM, after
        // this cycle's pop; an issue may only claim a free slot.
        occupancy = {1'b0, cnt_q} + {2'b00, inflight_q} - {2'b00, pop};
        case (state_q)
            RUN: begin
                if (bus.redirect_valid) begin
                    flush = 1'b1;
                    if (bus.redirect_pc[1:0] == 2'b00) begin
                        redir_ok = 1'b1;
                        issue    = 1'b1;
                        issue_pc = bus.redirect_pc;
                    end else begin
                        redir_bad = 1'b1;
                        state_d   = HALT;
                    end
                end else begin
                    push  = inflight_q;
                    issue = (occupancy < 3'd2);
                end
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = HALT;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // PC, in-flight tag and sticky fault
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q <= RESET_PC;
            tag_q      <= 32'h0;
            inflight_q <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            inflight_q <= issue;
            if (issue) begin
                fetch_pc_q <= issue_pc + 32'd4;
                tag_q      <= issue_pc;
            end
            if (redir_bad) begin
                fault_q <= 1'b1;
            end
        end
    end

    // A pop shifts entry 1 to the head, so the push lands at cnt - pop.
    assign wr_idx = cnt_q - {1'b0, pop};

    // Skid FIFO: shift-to-head storage so out_* read entry 0 directly
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q           <= 2'd0;
            fifo_pc_q[0]    <= 32'h0;
            fifo_pc_q[1]    <= 32'h0;
            fifo_instr_q[0] <= 32'h0;
            fifo_instr_q[1] <= 32'h0;
        end else if (flush) begin
            cnt_q <= 2'd0;
        end else begin
            if (pop) begin
                fifo_pc_q[0]    <= fifo_pc_q[1];
                fifo_instr_q[0] <= fifo_instr_q[1];
            end
            if (push) begin
                if (wr_idx == 2'd0) begin
                    fifo_pc_q[0]    <= tag_q;
                    fifo_instr_q[0] <= bus.imem_rdata;
                end else begin
                    fifo_pc_q[1]    <= tag_q;
                    fifo_instr_q[1] <= bus.imem_rdata;
                end
            end
            cnt_q <= cnt_q + {1'b0, push} - {1'b0, pop};
        end
    end
endmodule

// File: tb/tb_rv32i_fetch_unit.sv
// Bench for rv32i_fetch_unit: directed latency/redirect/fault/wrap/reset
// scenarios followed by randomized ready/redirect/reset traffic. The expected
// instruction stream is a list of consecutive PCs from each restart point;
// a separate monitor pops it on every handshake.
module tb_rv32i_fetch_unit;
    localparam int          AW       = 12;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rv32i_fetch_unit_if #(.AWIDTH(AW)) bus ();

    rv32i_fetch_unit #(.AWIDTH(AW), .RESET_PC(RESET_PC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // ROM port A: registered read, mem[i] = A000_0000 + i
    always @(posedge clk) bus.imem_rdata <= 32'hA000_0000 + 32'(bus.imem_addr);

    typedef struct {
        int          ep;
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   vectors     = 0;
    int   miscompares = 0;
    int   drv_ep      = 0;
    int   mon_ep      = 0;
    bit   drv_halt    = 0;
    bit   mon_halt    = 0;
    int   cur         = 0;
    int   seg_age     = 0;

    function automatic logic [31:0] rom_word(input logic [31:0] pc);
        logic [AW-1:0] idx;
        idx = pc[AW+1:2];
        return 32'hA000_0000 + 32'(idx);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // New expected stream segment starting at pc
    task automatic seg(input logic [31:0] pc);
        drv_ep++;
        seg_age = 0;
        for (int i = 0; i < 48; i++) begin
            e.ep    = drv_ep;
            e.pc    = pc + 32'(4 * i);
            e.instr = rom_word(e.pc);
            exp_q.push_back(e);
        end
    endtask

    task automatic goto(input int c);
        while (cur < c) begin
            @(posedge clk);
            #1;
            cur++;
        end
    endtask

    task automatic do_reset();
        rst_n          = 1'b0;
        redirect_clear();
        drv_halt       = 0;
        seg(RESET_PC);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        cur   = 0;
    endtask

    task automatic redirect_clear();
        bus.redirect_valid = 1'b0;
    endtask

    task automatic set_redir(input logic [31:0] pc);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = pc;
        if (!drv_halt) begin
            if (pc[1:0] != 2'b00) begin
                drv_ep++;
                drv_halt = 1;
            end else begin
                seg(pc);
            end
        end
    endtask

    // Monitor: scoreboard on handshakes, stall stability, halt behaviour
    bit          prev_rstn = 1;
    bit          prev_v = 0, prev_rdy = 0, prev_redir = 0;
    logic [31:0] prev_pc = '0, prev_instr = '0;
    always @(negedge clk) begin
        if (!rst_n) begin
            if (prev_rstn) mon_ep++;
            mon_halt = 0;
            prev_v   = 0;
        end else begin
            if (prev_rstn && prev_v && !prev_rdy && !prev_redir) begin
                check("stall_valid", 32'(bus.out_valid), 32'd1);
                check("stall_pc", bus.out_pc, prev_pc);
                check("stall_instr", bus.out_instr, prev_instr);
            end
            if (mon_halt) begin
                check("halt_valid", 32'(bus.out_valid), 32'd0);
                check("halt_fault", 32'(bus.fetch_fault), 32'd1);
            end
            if (bus.out_valid && bus.out_ready) begin
                while (exp_q.size() > 0 && exp_q[0].ep < mon_ep) void'(exp_q.pop_front());
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL sb_underflow: got pc %h with nothing expected", bus.out_pc);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_pc", bus.out_pc, e.pc);
                    check("sb_instr", bus.out_instr, e.instr);
                end
            end
            if (bus.redirect_valid && !mon_halt) begin
                mon_ep++;
                if (bus.redirect_pc[1:0] != 2'b00) mon_halt = 1;
            end
            prev_v     = bus.out_valid;
            prev_rdy   = bus.out_ready;
            prev_redir = bus.redirect_valid;
            prev_pc    = bus.out_pc;
            prev_instr = bus.out_instr;
        end
        prev_rstn = rst_n;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] p;
        int          r;
        bus.out_ready      = 1'b1;
        bus.redirect_pc    = 32'h0;
        bus.redirect_valid = 1'b0;

        // Basic stream: valid rises in cycle 2, one instruction per cycle
        do_reset();
        @(negedge clk);
        check("c0_valid", 32'(bus.out_valid), 32'd0);
        goto(1);
        @(negedge clk);
        check("c1_valid", 32'(bus.out_valid), 32'd0);
        for (int c = 2; c < 8; c++) begin
            goto(c);
            @(negedge clk);
            check("stream_valid", 32'(bus.out_valid), 32'd1);
            check("stream_pc", bus.out_pc, 32'(4 * (c - 2)));
            check("stream_instr", bus.out_instr, 32'hA000_0000 + 32'(c - 2));
        end

        // Back-pressure in cycles 5..9
        do_reset();
        goto(5);
        bus.out_ready = 1'b0;
        goto(9);
        @(negedge clk);
        check("bp_pc", bus.out_pc, 32'd12);
        goto(10);
        bus.out_ready = 1'b1;
        goto(25);

        // Aligned redirect in cycle 6
        do_reset();
        goto(6);
        set_redir(32'h100);
        goto(7);
        redirect_clear();
        @(negedge clk);
        check("redir_bubble", 32'(bus.out_valid), 32'd0);
        goto(8);
        @(negedge clk);
        check("redir_valid", 32'(bus.out_valid), 32'd1);
        check("redir_pc", bus.out_pc, 32'h100);
        check("redir_instr", bus.out_instr, 32'hA000_0040);
        goto(9);
        @(negedge clk);
        check("redir_pc2", bus.out_pc, 32'h104);
        check("redir_instr2", bus.out_instr, 32'hA000_0041);

        // Misaligned redirect, then an ignored aligned one
        goto(12);
        set_redir(32'h102);
        goto(13);
        redirect_clear();
        @(negedge clk);
        check("mis_fault", 32'(bus.fetch_fault), 32'd1);
        check("mis_valid", 32'(bus.out_valid), 32'd0);
        goto(16);
        set_redir(32'h200);
        goto(17);
        redirect_clear();
        goto(20);
        @(negedge clk);
        check("halt_hold_fault", 32'(bus.fetch_fault), 32'd1);
        check("halt_hold_valid", 32'(bus.out_valid), 32'd0);
        do_reset();
        @(negedge clk);
        check("post_halt_fault", 32'(bus.fetch_fault), 32'd0);
        goto(2);
        @(negedge clk);
        check("post_halt_pc", bus.out_pc, 32'h0);
        check("post_halt_valid", 32'(bus.out_valid), 32'd1);

        // Address wrap at the top of the ROM
        goto(3);
        set_redir(32'h3FFC);
        @(negedge clk);
        check("wrap_addr0", 32'(bus.imem_addr), 32'hFFF);
        goto(4);
        redirect_clear();
        @(negedge clk);
        check("wrap_addr1", 32'(bus.imem_addr), 32'h000);
        goto(5);
        @(negedge clk);
        check("wrap_pc0", bus.out_pc, 32'h3FFC);
        check("wrap_instr0", bus.out_instr, 32'hA000_0FFF);
        goto(6);
        @(negedge clk);
        check("wrap_pc1", bus.out_pc, 32'h4000);
        check("wrap_instr1", bus.out_instr, 32'hA000_0000);

        // Asynchronous reset with the FIFO full under stall
        do_reset();
        goto(3);
        bus.out_ready = 1'b0;
        goto(8);
        @(negedge clk);
        check("full_valid", 32'(bus.out_valid), 32'd1);
        check("full_pc", bus.out_pc, 32'd4);
        goto(9);
        rst_n = 1'b0;
        #1;
        check("arst_valid", 32'(bus.out_valid), 32'd0);
        check("arst_fault", 32'(bus.fetch_fault), 32'd0);
        check("arst_pc", bus.out_pc, 32'd0);
        check("arst_instr", bus.out_instr, 32'd0);
        bus.out_ready = 1'b1;
        do_reset();
        goto(1);
        @(negedge clk);
        check("arst_c1_valid", 32'(bus.out_valid), 32'd0);
        goto(2);
        @(negedge clk);
        check("arst_c2_valid", 32'(bus.out_valid), 32'd1);
        check("arst_c2_pc", bus.out_pc, 32'd0);

        // Randomized traffic
        for (int i = 0; i < 800; i++) begin
            goto(cur + 1);
            redirect_clear();
            bus.out_ready = ($urandom_range(0, 3) != 0);
            r = $urandom_range(0, 199);
            if (drv_halt && r < 10) begin
                do_reset();
            end else if (r < 2) begin
                p = $urandom();
                if (p[1:0] == 2'b00) p[0] = 1'b1;
                set_redir(p);
            end else if (r < 14 || seg_age >= 36) begin
                p = $urandom();
                p[1:0] = 2'b00;
                set_redir(p);
            end
            seg_age++;
        end
        goto(cur + 1);
        redirect_clear();
        goto(cur + 4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/rv32i_fetch_unit.md
Name: rv32i_fetch_unit

Overview:
Instruction fetch stage for the RV32I core. It owns the PC, drives the word address of the dual-port instruction ROM (port A, synchronous read, 1-cycle latency, no read enable), and hands instruction/PC pairs to decode over a valid/ready handshake. A 2-entry skid FIFO absorbs ROM latency and decode back-pressure. Branch/jump redirects flush the FIFO and restart fetch.

Parameters:
AWIDTH, 12, ROM word-address width (ROM depth 2**AWIDTH words)
RESET_PC, 32'h0000_0000, PC fetched first after reset

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
imem_addr  output  AWIDTH  ROM port-A word address
imem_rdata  input  32  ROM port-A read data, valid 1 cycle after address
redirect_valid  input  1  redirect request, single cycle
redirect_pc  input  32  redirect target byte address
out_valid  output  1  out_pc/out_instr hold a valid instruction
out_ready  input  1  decode accepts this cycle
out_pc  output  32  byte PC of the presented instruction
out_instr  output  32  presented instruction word
fetch_fault  output  1  sticky: misaligned redirect target

Behaviour:
- Clock is clk; reset is asynchronous, active-low, on rst_n.
- Reset values: fetch_pc=RESET_PC, FIFO empty, inflight=0, state=RUN, out_valid=0, out_pc=0, out_instr=0, fetch_fault=0.
- imem_addr is combinational: redirect_valid ? redirect_pc[AWIDTH+1:2] : fetch_pc[AWIDTH+1:2]. PC bits above AWIDTH+1 are ignored, so addresses wrap modulo ROM size. out_pc carries the full 32-bit PC.
- FIFO: 2 entries of {pc, instr}, registered. out_* always show the head entry; out_valid=1 iff non-empty. out_* stay stable while out_valid=1 and out_ready=0.
- pop = out_valid & out_ready.
- An issue is allowed when (fifo_cnt + inflight - pop) < 2 and state=RUN.
- On issue: fetch_pc <= fetch_pc+4; inflight <= 1; issued pc tag registered.
- When not issuing, imem_addr keeps its value. The resulting ROM re-read is harmless and is discarded (inflight=0).
- Response: when inflight=1 in a cycle, push {tag, imem_rdata} into the FIFO at the end of that cycle.
- Latency: address issued in cycle N, ROM data in N+1, out_valid in N+2. After reset release, cycle 0 issues RESET_PC and out_valid rises in cycle 2.
- Throughput: 1 instruction/cycle with out_ready held high.
- Redirect (state RUN, redirect_pc[1:0]==0):
  - FIFO cleared and the in-flight response dropped.
  - redirect_pc is issued in the same cycle (the FIFO counts as empty); fetch_pc <= redirect_pc+4.
  - out_valid is 0 in N+1; the target appears in N+2.
  - A pop in the redirect cycle is still a completed handshake. The flush applies to everything else.
- Misaligned redirect (redirect_pc[1:0]!=0):
  - Flush as above, no issue, state <= HALT, fetch_fault <= 1.
  - HALT: no issue, no push, out_valid=0, further redirects ignored. Only reset leaves HALT.
- States: RUN -> HALT on misaligned redirect. HALT -> RUN only via rst_n.
- Simultaneous push and pop with the FIFO full: legal, occupancy unchanged. The issue rule guarantees a push never finds the FIFO full without a pop.
- Reset asserted mid-operation: all state returns to reset values immediately, asynchronously. Fetch restarts from RESET_PC on release.

Test Plan:
- ROM model mem[i]=32'hA000_0000+i, RESET_PC=0, out_ready=1. Expect out_valid to rise in cycle 2 after release. Expect out_pc 0,4,8,... with out_instr A0000000, A0000001, A0000002, one per cycle, no gaps.
- Back-pressure: drop out_ready in cycles 5-9 and raise it in cycle 10. Expect out_* frozen on the same pc while stalled. Expect the stream to resume in order with no loss or duplicate; scoreboard pc/instr against the ROM model.
- Redirect to 0x100 in cycle 6. Expect out_valid=0 in cycle 7. Expect out_pc=0x100, out_instr=A0000040 in cycle 8, then 0x104/A0000041. No pre-redirect PC may appear after cycle 6.
- Redirect to 0x102. Expect fetch_fault=1 and out_valid=0 from the next cycle. Both hold through a later aligned redirect until rst_n pulses; after reset, fetch resumes from 0.
- Wrap (AWIDTH=12): redirect to 0x3FFC. Expect out_pc 0x3FFC/instr A0000FFF, then out_pc 0x4000/instr A0000000. Expect imem_addr 0xFFF, then 0x000.
- Assert rst_n low mid-stall with the FIFO full. Expect out_valid, fetch_fault, out_pc and out_instr at 0 before the next clock edge. After release, behaviour matches the first scenario.
